bit_stream_deserializer: RTL and testbench

//   Receive-side partner of the combinational bit-order blocks.

---
 rtl/bit_stream_deserializer.sv | 105 ++++++++++
 tb/tb_bit_stream_deserializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_deserializer.sv
// Serial-to-parallel deserializer: gathers one bit per accepted beat into a
// WIDTH-bit word with per-word selectable bit order, and presents finished
// words through a one-word holding register on a valid/ready interface.
module bit_stream_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             lsb_first,
    input  logic             s_bit,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Registered state and its next values
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic             order_q;
    logic             order_nx;
    logic [WIDTH-1:0] m_data_nx;
    logic             m_valid_nx;

    // Per-beat helpers
    logic             acc;
    logic             last_beat;
    logic             order_cur;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] word_c;

    // State register: partial word, latched bit order and output holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            shreg   <= '0;
            order_q <= 1'b1;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            shreg   <= shreg_nx;
            order_q <= order_nx;
            m_data  <= m_data_nx;
            m_valid <= m_valid_nx;
        end
    end

    // Bit placement: bit 0 of a word takes the live order, later bits the latched one
    always_comb begin
        last_beat = (cnt == LAST);
        order_cur = (cnt == '0) ? lsb_first : order_q;
        pos       = order_cur ? cnt : (LAST - cnt);
        for (int i = 0; i < int'(WIDTH); i++) begin
            word_c[i] = (CW'(i) == pos) ? s_bit : shreg[i];
        end
    end

    // Next-state: consume frees the holder, a completing beat reloads it in the same edge
    always_comb begin
        cnt_nx     = cnt;
        shreg_nx   = shreg;
        order_nx   = order_q;
        m_data_nx  = m_data;
        m_valid_nx = m_valid;

        if (m_valid && m_ready) begin
            m_valid_nx = 1'b0;
        end

        if (clear) begin
            cnt_nx   = '0;
            shreg_nx = '0;
        end else if (acc) begin
            if (cnt == '0) begin
                order_nx = lsb_first;
            end
            if (last_beat) begin
                m_data_nx  = word_c;
                m_valid_nx = 1'b1;
                cnt_nx     = '0;
                shreg_nx   = '0;
            end else begin
                shreg_nx = word_c;
                cnt_nx   = cnt + CW'(1);
            end
        end
    end

    // Outputs: stall only when the next bit would finish a word that cannot be stored
    always_comb begin
        s_ready = !rst && !clear && !(m_valid && !m_ready && last_beat);
        acc     = s_valid && s_ready;
        busy    = (cnt != '0);
    end

endmodule

// File: tb/tb_bit_stream_deserializer.sv
// Bench for bit_stream_deserializer (WIDTH=4): directed scenarios plus random
// traffic, checked against a bit-list reference model and a word scoreboard.
module tb_bit_stream_deserializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         lsb_first;
    logic         s_bit;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         busy;

    always #5 clk = ~clk;

    bit_stream_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .lsb_first (lsb_first),
        .s_bit     (s_bit),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: bits of the current word in arrival order, its order,
    // whether the output holder is occupied, and the expected-word scoreboard
    logic [W-1:0] sb[$];
    bit           bits[$];
    bit           word_lsb = 1'b1;
    bit           out_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !rst && !clear && !(out_full && !m_ready && bits.size() == W - 1);
    endfunction

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_edge(input bit accepted);
        bit           load = 1'b0;
        logic [W-1:0] w;
        if (rst) begin
            bits.delete();
            word_lsb = 1'b1;
            out_full = 1'b0;
            sb.delete();
            return;
        end
        if (clear) begin
            bits.delete();
        end else if (accepted) begin
            if (bits.size() == 0) word_lsb = lsb_first;
            bits.push_back(s_bit);
            if (bits.size() == W) begin
                w = '0;
                for (int k = 0; k < int'(W); k++) begin
                    if (word_lsb) w[k] = bits[k];
                    else          w[int'(W) - 1 - k] = bits[k];
                end
                sb.push_back(w);
                bits.delete();
                load = 1'b1;
            end
        end
        out_full = (out_full && !m_ready) || load;
    endtask

    // One cycle: drive inputs, check handshake outputs, clock the model
    task automatic cycle(input bit r, input bit c, input bit l, input bit b,
                         input bit v, input bit mr, output bit accepted);
        bit exp_ready;
        rst = r; clear = c; lsb_first = l; s_bit = b; s_valid = v; m_ready = mr;
        #1;
        exp_ready = model_ready();
        check("s_ready", 32'(s_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(bits.size() != 0));
        accepted = v && exp_ready;
        @(posedge clk);
        model_edge(accepted);
        #1;
    endtask

    task automatic idle(input bit mr);
        bit a;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mr, a);
    endtask

    // Present one bit until accepted, with a bounded number of attempts
    task automatic send(input bit b, input bit l, input bit mr);
        bit a = 1'b0;
        for (int t = 0; t < 10 && !a; t++) begin
            cycle(1'b0, 1'b0, l, b, 1'b1, mr, a);
        end
        if (!a) check("send_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        bit a;
        bit r, c, v, mr;
        rst = 1'b1; clear = 1'b0; lsb_first = 1'b1; s_bit = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk);
        #1;

        fork
            // Monitor: compare the held word each cycle, retire it on consume
            forever begin
                @(negedge clk);
                check("m_valid", 32'(m_valid), 32'(sb.size() != 0));
                if (m_valid && sb.size() > 0) begin
                    check("m_data", 32'(m_data), 32'(sb[0]));
                    if (m_ready) void'(sb.pop_front());
                end
            end
        join_none

        // Reset state
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, a);
        check("rst_m_data", 32'(m_data), 32'(0));
        check("rst_m_valid", 32'(m_valid), 32'(0));

        // LSB-first 1,0,1,1 -> 4'b1101 for exactly one cycle
        send(1'b1, 1'b1, 1'b1); send(1'b0, 1'b1, 1'b1); send(1'b1, 1'b1, 1'b1); send(1'b1, 1'b1, 1'b1);
        check("lsb_word", 32'(m_data), 32'(4'b1101));
        check("lsb_valid", 32'(m_valid), 32'(1));
        idle(1'b1);
        check("lsb_one_cycle", 32'(m_valid), 32'(0));

        // MSB-first same bits -> 4'b1011
        send(1'b1, 1'b0, 1'b1); send(1'b0, 1'b0, 1'b1); send(1'b1, 1'b0, 1'b1); send(1'b1, 1'b0, 1'b1);
        check("msb_word", 32'(m_data), 32'(4'b1011));
        idle(1'b1);

        // Backpressure: 4'h3 held, stall on last bit of 4'hA, then consume+load
        send(1'b1, 1'b1, 1'b0); send(1'b1, 1'b1, 1'b0); send(1'b0, 1'b1, 1'b0); send(1'b0, 1'b1, 1'b0);
        check("bp_hold_word", 32'(m_data), 32'(4'h3));
        send(1'b0, 1'b1, 1'b0); send(1'b1, 1'b1, 1'b0); send(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a);
        check("bp_stall", 32'(a), 32'(0));
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a);
        check("bp_stall2", 32'(a), 32'(0));
        check("bp_still_held", 32'(m_data), 32'(4'h3));
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, a);
        check("bp_accept", 32'(a), 32'(1));
        check("bp_next_word", 32'(m_data), 32'(4'hA));
        check("bp_next_valid", 32'(m_valid), 32'(1));
        idle(1'b1);
        idle(1'b1);

        // Clear mid-word: bit during clear ignored, then 0,1,1,0 -> 4'h6
        send(1'b1, 1'b1, 1'b1); send(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, a);
        check("clear_no_accept", 32'(a), 32'(0));
        check("clear_busy", 32'(busy), 32'(0));
        send(1'b0, 1'b1, 1'b1); send(1'b1, 1'b1, 1'b1); send(1'b1, 1'b1, 1'b1); send(1'b0, 1'b1, 1'b1);
        check("clear_word", 32'(m_data), 32'(4'h6));
        idle(1'b1);

        // Order latched at bit 0: 1,0,0,0 -> 4'h1 then MSB-first word -> 4'h8
        send(1'b1, 1'b1, 1'b1); send(1'b0, 1'b0, 1'b1); send(1'b0, 1'b0, 1'b1); send(1'b0, 1'b0, 1'b1);
        check("order_latched", 32'(m_data), 32'(4'h1));
        send(1'b1, 1'b0, 1'b1); send(1'b0, 1'b1, 1'b1); send(1'b0, 1'b1, 1'b1); send(1'b0, 1'b1, 1'b1);
        check("order_next", 32'(m_data), 32'(4'h8));
        idle(1'b1);

        // Reset mid-word while a word is held
        send(1'b1, 1'b1, 1'b0); send(1'b0, 1'b1, 1'b0); send(1'b1, 1'b1, 1'b0); send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0); send(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a);
        check("midrst_m_valid", 32'(m_valid), 32'(0));
        check("midrst_m_data", 32'(m_data), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        idle(1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 9) < 7);
            mr = ($urandom_range(0, 9) < 6);
            cycle(r, c, 1'($urandom), 1'($urandom), v, mr, a);
        end
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
